indication_input_demux: RTL and testbench

- Parametrised successor to the single-method indication input stage.
- Accepts tagged messages from a portal pipe (tag in the low bits, payload above it), buffers them in a DEPTH-entry FIFO, and dispatches each one to one of NUM_METHODS indication methods selected by tag.
- Messages with an unrecognised tag are dropped and reported on an error strobe and a saturating counter.
- Sits between the portal transport pipe and the user indication interface.

---
 rtl/indication_input_demux_if.sv | 25 ++
 rtl/indication_input_demux.sv | 59 +++++
 tb/tb_indication_input_demux.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/indication_input_demux_if.sv
// indication_input_demux_if: pipe enqueue, per-method indication dispatch and bad-tag report bundle.
interface indication_input_demux_if #(
  parameter int NUM_METHODS = 4,
  parameter int TAG_WIDTH   = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int ERR_WIDTH   = 16
);
  logic                            i_pipe_enq_ena;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] i_pipe_enq_v;
  logic                            o_pipe_enq_rdy;
  logic [NUM_METHODS-1:0]          o_call_ena;
  logic [DATA_WIDTH-1:0]           o_call_v;
  logic [NUM_METHODS-1:0]          i_call_rdy;
  logic                            o_badtag_ena;
  logic [TAG_WIDTH-1:0]            o_badtag_tag;
  logic [ERR_WIDTH-1:0]            o_err_count;
  modport master (
    output i_pipe_enq_ena, i_pipe_enq_v, i_call_rdy,
    input  o_pipe_enq_rdy, o_call_ena, o_call_v, o_badtag_ena, o_badtag_tag, o_err_count
  );
  modport slave (
    input  i_pipe_enq_ena, i_pipe_enq_v, i_call_rdy,
    output o_pipe_enq_rdy, o_call_ena, o_call_v, o_badtag_ena, o_badtag_tag, o_err_count
  );
endinterface

// File: rtl/indication_input_demux.sv
// indication_input_demux: FIFO-buffered tagged messages dispatched in order to one of NUM_METHODS methods.
module indication_input_demux #(
  parameter int NUM_METHODS = 4,
  parameter int FIRST_TAG   = 1,
  parameter int TAG_WIDTH   = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 4,
  parameter int ERR_WIDTH   = 16
) (
  input logic CLK,
  input logic RST,
  indication_input_demux_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = TAG_WIDTH + DATA_WIDTH;
  logic [MW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_rd, r_wr;
  logic [AW:0]            r_cnt;
  logic [ERR_WIDTH-1:0]   r_err;
  logic                   w_empty, w_valid, w_bad, w_push, w_pop;
  logic [MW-1:0]          w_head;
  logic [TAG_WIDTH-1:0]   w_tag, w_idx;
  logic [NUM_METHODS-1:0] w_ena;
  assign w_empty = r_cnt == '0;
  assign w_head  = r_mem[r_rd];
  assign w_tag   = w_head[TAG_WIDTH-1:0];
  assign w_idx   = w_tag - TAG_WIDTH'(FIRST_TAG);
  assign w_valid = !w_empty && w_tag >= TAG_WIDTH'(FIRST_TAG) && w_idx < TAG_WIDTH'(NUM_METHODS);
  assign w_bad   = !w_empty && !w_valid;
  always_comb begin
    w_ena = '0;
    for (int i = 0; i < NUM_METHODS; i++) w_ena[i] = w_valid && w_idx == TAG_WIDTH'(i) && bus.i_call_rdy[i];
  end
  // Bad heads pop regardless of ready so they can never block the queue.
  assign w_pop  = w_bad || (|w_ena);
  assign w_push = bus.i_pipe_enq_ena && bus.o_pipe_enq_rdy;
  assign bus.o_pipe_enq_rdy = !RST && r_cnt != (AW+1)'(DEPTH);
  assign bus.o_call_ena     = w_ena;
  assign bus.o_call_v       = w_empty ? '0 : w_head[MW-1:TAG_WIDTH];
  assign bus.o_badtag_ena   = w_bad;
  assign bus.o_badtag_tag   = w_bad ? w_tag : '0;
  assign bus.o_err_count    = r_err;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_err <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_bad && r_err != '1) r_err <= r_err + ERR_WIDTH'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= bus.i_pipe_enq_v;
  end
endmodule

// File: tb/tb_indication_input_demux.sv
// tb_indication_input_demux: directed + random stimulus against a queue model, scoreboard monitor.
module tb_indication_input_demux;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  indication_input_demux_if #(.ERR_WIDTH(16)) b ();
  indication_input_demux_if #(.ERR_WIDTH(2))  b2 ();
  indication_input_demux dut (.CLK(clk), .RST(rst), .bus(b));
  indication_input_demux #(.ERR_WIDTH(2)) dut2 (.CLK(clk), .RST(rst), .bus(b2));
  assign b2.i_pipe_enq_ena = b.i_pipe_enq_ena;
  assign b2.i_pipe_enq_v   = b.i_pipe_enq_v;
  assign b2.i_call_rdy     = b.i_call_rdy;
  typedef struct {
    bit          bad;
    int          idx;
    logic [31:0] tag;
    logic [63:0] pl;
  } ev_t;
  ev_t mq[$];
  ev_t sbq[$];
  int checks = 0;
  int errors = 0;
  int merr = 0;
  bit exp_pop = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cycle(bit e, logic [31:0] tag, logic [63:0] pl, logic [3:0] rdy);
    ev_t h;
    bit full;
    @(negedge clk);
    b.i_pipe_enq_ena = e;
    b.i_pipe_enq_v   = {pl, tag};
    b.i_call_rdy     = rdy;
    #1;
    full = mq.size() == DEPTH;
    chk("enq_rdy", b.o_pipe_enq_rdy, !full);
    chk("err_count", b.o_err_count, merr);
    chk("err_count_sat", b2.o_err_count, merr > 3 ? 3 : merr);
    exp_pop = 0;
    if (mq.size() != 0) begin
      h = mq[0];
      exp_pop = h.bad || rdy[h.idx];
      if (exp_pop) begin
        if (h.bad) merr++;
        void'(mq.pop_front());
      end
    end
    if (e && !full) begin
      h.bad = !(tag >= 1 && tag <= 4);
      h.idx = h.bad ? 0 : int'(tag) - 1;
      h.tag = tag;
      h.pl  = pl;
      mq.push_back(h);
      sbq.push_back(h);
    end
  endtask
  task automatic mid_reset();
    @(negedge clk);
    b.i_pipe_enq_ena = 0;
    b.i_call_rdy = 0;
    exp_pop = 0;
    #3 rst = 1;
    #1;
    chk("mid_rst_rdy", b.o_pipe_enq_rdy, 0);
    chk("mid_rst_ena", b.o_call_ena, 0);
    chk("mid_rst_err", b.o_err_count, 0);
    mq.delete();
    sbq.delete();
    merr = 0;
    @(negedge clk);
    #3 rst = 0;
  endtask
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("pop", (|b.o_call_ena) || b.o_badtag_ena, exp_pop);
      if ((|b.o_call_ena) || b.o_badtag_ena) begin
        if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
        else begin
          e = sbq.pop_front();
          if (e.bad) begin
            chk("badtag_ena", b.o_badtag_ena, 1);
            chk("badtag_tag", b.o_badtag_tag, e.tag);
            chk("call_ena_on_bad", b.o_call_ena, 0);
          end else begin
            chk("call_ena", b.o_call_ena, 64'(4'b1 << e.idx));
            chk("call_v", b.o_call_v, e.pl);
            chk("badtag_on_call", b.o_badtag_ena, 0);
          end
        end
      end
    end
  end
  initial begin
    b.i_pipe_enq_ena = 0;
    b.i_pipe_enq_v   = '0;
    b.i_call_rdy     = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_rdy", b.o_pipe_enq_rdy, 0);
      chk("rst_ena", b.o_call_ena, 0);
      chk("rst_err", b.o_err_count, 0);
    end
    rst = 0;
    cycle(1, 3, 64'hDEAD_BEEF_0000_0002, 4'hF);
    cycle(0, 0, 0, 4'hF);
    cycle(0, 0, 0, 4'hF);
    for (int i = 0; i < 5; i++) cycle(1, 1, 64'h1000 + 64'(i), 4'hE);
    repeat (2) cycle(0, 0, 0, 4'hE);
    repeat (6) cycle(0, 0, 0, 4'hF);
    cycle(1, 0, 64'hA0, 4'h0);
    cycle(1, 5, 64'hA1, 4'h0);
    cycle(1, 32'hFFFF_FFFF, 64'hA2, 4'h0);
    repeat (3) cycle(0, 0, 0, 4'h0);
    cycle(1, 2, 64'hB0, 4'hD);
    cycle(1, 3, 64'hB1, 4'hD);
    repeat (3) cycle(0, 0, 0, 4'hD);
    repeat (3) cycle(0, 0, 0, 4'hF);
    cycle(1, 7, 64'hC0, 4'hF);
    cycle(1, 0, 64'hC1, 4'hF);
    repeat (2) cycle(0, 0, 0, 4'hF);
    for (int i = 0; i < 3; i++) cycle(1, 32'(i + 1), 64'hD0 + 64'(i), 4'h0);
    mid_reset();
    repeat (4) cycle(0, 0, 0, 4'hF);
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [31:0] t;
      r = $urandom_range(0, 9);
      t = r < 7 ? 32'(r) : (r == 7 ? 32'hFFFF_FFFF : 32'($urandom));
      cycle($urandom_range(0, 3) != 0, t, {32'($urandom), 32'($urandom)},
            $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 50 && mq.size() != 0; k++) cycle(0, 0, 0, 4'hF);
    repeat (2) cycle(0, 0, 0, 4'hF);
    #2;
    chk("drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
